ez90_cpuid_sched: RTL and testbench

- Shares one combinational CPUID leaf model (cpuid_block) between NUM_REQ requesters (per-core CSR-window front ends, debug port).
- Provides per-requester valid/ready request and response channels and a round-robin grant.
- Registers the selected leaf/subleaf, captures the four 64-bit result lanes, and holds them until the owning requester accepts.
- Sits between the eZ90 CSR-window decode and the single cpuid_block instance in the core cluster.

---
 rtl/ez90_cpuid_sched_pkg.sv | 21 ++
 rtl/ez90_cpuid_sched_arb.sv | 33 +++
 rtl/ez90_cpuid_sched.sv | 130 +++++++++++++
 tb/tb_ez90_cpuid_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ez90_cpuid_sched_pkg.sv
// Shared eZ90/carbon architecture constants and types.
// Used by the CPUID scheduler and other fabric schedulers.
package carbon_arch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } ez90_cpuid_sched_state_t;

  localparam int CARBON_CPUID_RSP_LANES = 4;

  localparam logic [31:0] CARBON_CPUID_LEAF_VENDOR   = 32'h0000_0000;
  localparam logic [31:0] CARBON_CPUID_LEAF_TOPOLOGY = 32'h0000_000B;
  localparam logic [15:0] CARBON_CPUID_CORE_COUNT    = 16'd8;

  function automatic int carbon_idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ez90_cpuid_sched_arb.sv
// carbon_rr_arbiter: combinational round-robin pick, searching
// upward from ptr with wrap; one-hot grant plus encoded index.
module carbon_rr_arbiter
  import carbon_arch_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = carbon_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               vld
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ez90_cpuid_sched.sv
// eZ90 CPUID scheduler: shares one cpuid_block among NUM_REQ requesters.
// Optional response-hold timeout: define EZ90_CPUID_RSP_TIMEOUT_EN.
module ez90_cpuid_sched
  import carbon_arch_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_leaf,
  input  logic [NUM_REQ*32-1:0] req_subleaf,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [255:0]          rsp_data,
  output logic [31:0]           cpuid_leaf,
  output logic [31:0]           cpuid_subleaf,
  input  logic [63:0]           cpuid_data0,
  input  logic [63:0]           cpuid_data1,
  input  logic [63:0]           cpuid_data2,
  input  logic [63:0]           cpuid_data3,
  output logic                  busy
`ifdef EZ90_CPUID_RSP_TIMEOUT_EN
  ,
  output logic                  rsp_timeout
`endif
);

  localparam int IW = carbon_idx_w(NUM_REQ);
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LOOKUP = LOOKUP;
  localparam logic [1:0] S_RESP   = RESP;

  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num
    $error("ez90_cpuid_sched: NUM_REQ must be 1..8");
  end
  if (RSP_TIMEOUT < 1 || RSP_TIMEOUT > 65535) begin : g_bad_to
    $error("ez90_cpuid_sched: RSP_TIMEOUT must be 1..65535");
  end

  logic [1:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      id;
  logic [IW-1:0]      nxt_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [NUM_REQ-1:0] id_oh;
  logic [31:0]        sel_leaf;
  logic [31:0]        sel_sub;
  logic               in_idle;
  logic               in_resp;
  logic               rsp_fire;
  logic               hold_hit;

  carbon_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  assign in_idle = (state == S_IDLE);
  assign in_resp = (state == S_RESP);
  assign busy    = !in_idle;

  always_comb begin
    id_oh     = '0;
    id_oh[id] = 1'b1;
    sel_leaf  = req_leaf[int'(gnt_idx)*32 +: 32];
    sel_sub   = req_subleaf[int'(gnt_idx)*32 +: 32];
  end

  assign nxt_ptr   = (int'(id) == NUM_REQ-1) ? '0 : id + IW'(1);
  assign req_ready = in_idle ? gnt : '0;
  assign rsp_valid = (in_resp && !hold_hit) ? id_oh : '0;
  assign rsp_fire  = |(rsp_valid & rsp_ready);

`ifdef EZ90_CPUID_RSP_TIMEOUT_EN
  logic [15:0] hold_cnt;

  assign hold_hit    = in_resp && (hold_cnt == 16'(RSP_TIMEOUT));
  assign rsp_timeout = hold_hit;

  always_ff @(posedge clk) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if (state == S_LOOKUP)
      hold_cnt <= '0;
    else if (in_resp && !rsp_fire && !hold_hit)
      hold_cnt <= hold_cnt + 16'd1;
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      id            <= '0;
      cpuid_leaf    <= '0;
      cpuid_subleaf <= '0;
      rsp_data      <= '0;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          id            <= gnt_idx;
          cpuid_leaf    <= sel_leaf;
          cpuid_subleaf <= sel_sub;
          state         <= S_LOOKUP;
        end
        S_LOOKUP: begin
          rsp_data <= {cpuid_data3, cpuid_data2,
                       cpuid_data1, cpuid_data0};
          state    <= S_RESP;
        end
        S_RESP: if (rsp_fire || hold_hit) begin
          rr_ptr <= nxt_ptr;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ez90_cpuid_sched.sv
// Directed self-checking bench for ez90_cpuid_sched (NUM_REQ=2).
// Timeout scenario is compiled when EZ90_CPUID_RSP_TIMEOUT_EN is defined.
module tb_ez90_cpuid_sched;
  import carbon_arch_pkg::*;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_leaf;
  logic [N*32-1:0] req_subleaf;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [255:0]   rsp_data;
  logic [31:0]    cpuid_leaf;
  logic [31:0]    cpuid_subleaf;
  logic [63:0]    d0, d1, d2, d3;
  logic           busy;
`ifdef EZ90_CPUID_RSP_TIMEOUT_EN
  logic           rsp_timeout;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [255:0] EXP_TOPO3 = {
    64'h0000_0000_0000_000B, 64'h0,
    64'h0000_0000_0000_0003, 64'h0000_0000_0000_0008};

  always #5 clk = ~clk;

  ez90_cpuid_sched #(.NUM_REQ(N), .RSP_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_leaf      (req_leaf),
    .req_subleaf   (req_subleaf),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .cpuid_leaf    (cpuid_leaf),
    .cpuid_subleaf (cpuid_subleaf),
    .cpuid_data0   (d0),
    .cpuid_data1   (d1),
    .cpuid_data2   (d2),
    .cpuid_data3   (d3),
    .busy          (busy)
`ifdef EZ90_CPUID_RSP_TIMEOUT_EN
    ,
    .rsp_timeout   (rsp_timeout)
`endif
  );

  // cpuid_block stand-in
  always_comb begin
    d0 = '0;
    d1 = '0;
    d2 = '0;
    d3 = '0;
    if (cpuid_leaf == CARBON_CPUID_LEAF_VENDOR) begin
      d0 = 64'h0000_0000_0000_000B;
      d1 = 64'h0000_0000_4252_4143;
      d2 = 64'h0000_0000_3039_5A45;
    end else if (cpuid_leaf == CARBON_CPUID_LEAF_TOPOLOGY) begin
      d0 = {48'h0, CARBON_CPUID_CORE_COUNT};
      d1 = {32'h0, cpuid_subleaf};
      d3 = 64'h0000_0000_0000_000B;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy got %b want 0", busy);
    end
    n_chk++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL rst_req_ready got %b want 00", req_ready);
    end
    n_chk++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL rst_rsp_valid got %b want 00", rsp_valid);
    end
    n_chk++;
    if (rsp_data !== 256'h0) begin
      n_fail++; $display("FAIL rst_rsp_data got %h want 0", rsp_data);
    end
    n_chk++;
    if ({cpuid_leaf, cpuid_subleaf} !== 64'h0) begin
      n_fail++; $display("FAIL rst_leaf got %h/%h want 0/0", cpuid_leaf, cpuid_subleaf);
    end
  endtask

  task automatic test_single();
    rsp_ready = 2'b01;
    req_leaf[31:0] = CARBON_CPUID_LEAF_VENDOR;
    req_subleaf[31:0] = 32'h0;
    req_valid = 2'b01;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL single_req_ready got %b want 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    n_chk++;
    if ({busy, req_ready, rsp_valid} !== 5'b1_00_00) begin
      n_fail++; $display("FAIL single_lookup got %b want 10000", {busy, req_ready, rsp_valid});
    end
    step();
    n_chk++;
    if (rsp_valid !== 2'b01) begin
      n_fail++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid);
    end
    n_chk++;
    if (rsp_data[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL single_d0_hi got %h want 0", rsp_data[63:32]);
    end
    n_chk++;
    if (rsp_data[95:64] !== 32'h4252_4143) begin
      n_fail++; $display("FAIL single_word1 got %h want 42524143", rsp_data[95:64]);
    end
    step();
    n_chk++;
    if ({busy, rsp_valid} !== 3'b0_00) begin
      n_fail++; $display("FAIL single_done got %b want 000", {busy, rsp_valid});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_leaf = {CARBON_CPUID_LEAF_TOPOLOGY, CARBON_CPUID_LEAF_TOPOLOGY};
    req_subleaf = '0;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp = (n % 2 == 0) ? 2'b01 : 2'b10;
      n_chk++;
      if (req_ready !== exp) begin
        n_fail++; $display("FAIL cont_grant%0d got %b want %b", n, req_ready, exp);
      end
      step();
      n_chk++;
      if (req_ready !== 2'b00) begin
        n_fail++; $display("FAIL cont_lookup%0d req_ready got %b want 00", n, req_ready);
      end
      step();
      n_chk++;
      if (rsp_valid !== exp) begin
        n_fail++; $display("FAIL cont_rsp%0d got %b want %b", n, rsp_valid, exp);
      end
      n_chk++;
      if (rsp_data[15:0] !== CARBON_CPUID_CORE_COUNT) begin
        n_fail++; $display("FAIL cont_cores%0d got %h want %h", n, rsp_data[15:0], CARBON_CPUID_CORE_COUNT);
      end
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    req_leaf[63:32] = CARBON_CPUID_LEAF_TOPOLOGY;
    req_subleaf[63:32] = 32'd3;
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL bp_grant got %b want 10", req_ready);
    end
    step();
    req_leaf[31:0] = CARBON_CPUID_LEAF_TOPOLOGY;
    req_subleaf[31:0] = 32'd5;
    req_valid = 2'b01;
    step();
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (rsp_valid !== 2'b10) begin
        n_fail++; $display("FAIL bp_hold%0d rsp_valid got %b want 10", i, rsp_valid);
      end
      n_chk++;
      if (rsp_data !== EXP_TOPO3) begin
        n_fail++; $display("FAIL bp_data%0d got %h want %h", i, rsp_data, EXP_TOPO3);
      end
      n_chk++;
      if (req_ready !== 2'b00) begin
        n_fail++; $display("FAIL bp_ready%0d got %b want 00", i, req_ready);
      end
      if (i < 9) step();
    end
    n_chk++;
    if (cpuid_subleaf !== 32'd3) begin
      n_fail++; $display("FAIL bp_subleaf got %h want 3", cpuid_subleaf);
    end
    rsp_ready = 2'b11;
    step();
    n_chk++;
    if ({rsp_valid, req_ready} !== 4'b00_01) begin
      n_fail++; $display("FAIL bp_release got %b want 0001", {rsp_valid, req_ready});
    end
    step();
    req_valid = 2'b00;
    step();
    n_chk++;
    if (rsp_valid !== 2'b01 || rsp_data[95:64] !== 32'd5) begin
      n_fail++; $display("FAIL bp_next got %b/%h want 01/5", rsp_valid, rsp_data[95:64]);
    end
    step();
  endtask

  task automatic test_unknown();
    req_leaf[31:0] = 32'hDEAD_0000;
    req_subleaf[31:0] = 32'h0;
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL unk_grant got %b want 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    n_chk++;
    if (rsp_valid !== 2'b01 || rsp_data !== 256'h0) begin
      n_fail++; $display("FAIL unk_rsp got %b/%h want 01/0", rsp_valid, rsp_data);
    end
    step();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL unk_done busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    req_leaf[31:0] = CARBON_CPUID_LEAF_TOPOLOGY;
    req_subleaf[31:0] = 32'd9;
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++;
    if ({busy, req_ready, rsp_valid, cpuid_leaf, cpuid_subleaf} !== 69'h0) begin
      n_fail++; $display("FAIL rst_lookup got %b/%h/%h want all 0", busy, cpuid_leaf, cpuid_subleaf);
    end
    req_leaf[63:32] = CARBON_CPUID_LEAF_VENDOR;
    req_subleaf[63:32] = 32'd1;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    n_chk++;
    if (rsp_valid !== 2'b10) begin
      n_fail++; $display("FAIL rst_pre_resp got %b want 10", rsp_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++;
    if ({busy, req_ready, rsp_valid} !== 5'b0) begin
      n_fail++; $display("FAIL rst_resp_ctl got %b want 00000", {busy, req_ready, rsp_valid});
    end
    n_chk++;
    if (rsp_data !== 256'h0 || cpuid_subleaf !== 32'h0) begin
      n_fail++; $display("FAIL rst_resp_data got %h/%h want 0/0", rsp_data, cpuid_subleaf);
    end
    req_leaf = {CARBON_CPUID_LEAF_TOPOLOGY, CARBON_CPUID_LEAF_VENDOR};
    req_subleaf = {32'd7, 32'd0};
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rst_ptr got %b want 01", req_ready);
    end
    step();
    req_valid = 2'b10;
    step();
    step();
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL rst_req1_grant got %b want 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    n_chk++;
    if (rsp_valid !== 2'b10 || rsp_data[127:64] !== 64'd7) begin
      n_fail++; $display("FAIL rst_req1_rsp got %b/%h want 10/7", rsp_valid, rsp_data[127:64]);
    end
    step();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_req1_done busy got %b want 0", busy);
    end
  endtask

`ifdef EZ90_CPUID_RSP_TIMEOUT_EN
  task automatic test_timeout();
    req_leaf[63:32] = CARBON_CPUID_LEAF_TOPOLOGY;
    req_subleaf[63:32] = 32'd2;
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL to_grant got %b want 10", req_ready);
    end
    step();
    req_leaf[31:0] = CARBON_CPUID_LEAF_VENDOR;
    req_valid = 2'b01;
    step();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({rsp_valid, rsp_timeout} !== 3'b10_0) begin
        n_fail++; $display("FAIL to_hold%0d got %b want 100", i, {rsp_valid, rsp_timeout});
      end
      step();
    end
    n_chk++;
    if ({rsp_valid, rsp_timeout} !== 3'b00_1) begin
      n_fail++; $display("FAIL to_pulse got %b want 001", {rsp_valid, rsp_timeout});
    end
    step();
    n_chk++;
    if ({rsp_timeout, req_ready} !== 3'b0_01) begin
      n_fail++; $display("FAIL to_next got %b want 001", {rsp_timeout, req_ready});
    end
    rsp_ready = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    n_chk++;
    if (rsp_valid !== 2'b01) begin
      n_fail++; $display("FAIL to_next_rsp got %b want 01", rsp_valid);
    end
    step();
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_leaf    = '0;
    req_subleaf = '0;
    rsp_ready   = '0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    test_single();
    test_contention();
    test_backpressure();
    test_unknown();
    test_reset_abort();
`ifdef EZ90_CPUID_RSP_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
